// File: rtl/bcd_scan_display_if.sv
// bcd_scan_display_if: the bus between the BCD time counters and the
// multiplexed 7-segment scanner.
//   Disp_EN                  display enable (1 = on)
//   Hour_H/L, Min_H/L, Sec_H/L  BCD time digits, tens/units
//   AN[5:0]                  digit enables, active-low, AN[0] = leftmost (Hour_H)
//   SEG[6:0]                 segments {g,f,e,d,c,b,a}, active-low
//   DP                       decimal point, active-low
// Modports: master = counter/board side, slave = scanner.
interface bcd_scan_display_if;
  logic       Disp_EN;
  logic [3:0] Hour_H;
  logic [3:0] Hour_L;
  logic [3:0] Min_H;
  logic [3:0] Min_L;
  logic [3:0] Sec_H;
  logic [3:0] Sec_L;
  logic [5:0] AN;
  logic [6:0] SEG;
  logic       DP;

  modport master (
    output Disp_EN, Hour_H, Hour_L, Min_H, Min_L, Sec_H, Sec_L,
    input  AN, SEG, DP
  );

  modport slave (
    input  Disp_EN, Hour_H, Hour_L, Min_H, Min_L, Sec_H, Sec_L,
    output AN, SEG, DP
  );
endinterface

// File: rtl/bcd_scan_display.sv
// bcd_scan_display: scans six BCD time digits onto a 6-digit common-anode
// multiplexed 7-segment display, one digit per scan slot of CLK_DIV cycles.
// Ports:
//   CP   system clock
//   CR   synchronous reset, active-high
//   bus  bcd_scan_display_if.slave (digits + Disp_EN in, AN/SEG/DP out)
// Parameters:
//   CLK_DIV  CP cycles per scan slot (2..2^20)
// Optional build macro:
//   COLON_BLINK_EN  separators on slots 1 and 3 blink with Sec_L[0]
// All outputs are registered; a frame snapshot of the digits is taken when the
// slot index wraps 5->0 so a frame never mixes values from two counter states.
module bcd_scan_display #(
  parameter int unsigned CLK_DIV = 50000
) (
  input logic                CP,
  input logic                CR,
  bcd_scan_display_if.slave  bus
);

  localparam int unsigned PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  logic [PW-1:0] r_presc;
  logic [2:0]    r_idx;
  logic [23:0]   r_snap;
  logic [5:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;

  logic        w_tick;
  logic        w_wrap;
  logic [2:0]  w_next_idx;
  logic [23:0] w_live;
  logic [23:0] w_frame;
  logic [3:0]  w_digit;
  logic [6:0]  w_seg;
  logic        w_dp;

  assign w_tick     = (r_presc == PRESC_MAX);
  assign w_wrap     = (r_idx == 3'd5);
  assign w_next_idx = w_wrap ? 3'd0 : r_idx + 3'd1;
  assign w_live     = {bus.Hour_H, bus.Hour_L, bus.Min_H, bus.Min_L, bus.Sec_H, bus.Sec_L};
  // Slot 0 is loaded on the same edge as the snapshot, so it must see the
  // value being captured rather than the previous frame's snapshot.
  assign w_frame    = w_wrap ? w_live : r_snap;

  always_comb begin
    w_digit = 4'd0;
    unique case (w_next_idx)
      3'd0:    w_digit = w_frame[23:20];
      3'd1:    w_digit = w_frame[19:16];
      3'd2:    w_digit = w_frame[15:12];
      3'd3:    w_digit = w_frame[11:8];
      3'd4:    w_digit = w_frame[7:4];
      3'd5:    w_digit = w_frame[3:0];
      default: w_digit = 4'd0;
    endcase
  end

  always_comb begin
    w_seg = 7'h3F;  // '-' flags a non-BCD digit from upstream
    case (w_digit)
      4'd0:    w_seg = 7'h40;
      4'd1:    w_seg = 7'h79;
      4'd2:    w_seg = 7'h24;
      4'd3:    w_seg = 7'h30;
      4'd4:    w_seg = 7'h19;
      4'd5:    w_seg = 7'h12;
      4'd6:    w_seg = 7'h02;
      4'd7:    w_seg = 7'h78;
      4'd8:    w_seg = 7'h00;
      4'd9:    w_seg = 7'h10;
      default: w_seg = 7'h3F;
    endcase
  end

  always_comb begin
    w_dp = 1'b1;
    if (w_next_idx == 3'd1 || w_next_idx == 3'd3) begin
`ifdef COLON_BLINK_EN
      w_dp = w_frame[0];  // dark on odd seconds
`else
      w_dp = 1'b0;
`endif
    end
  end

  always_ff @(posedge CP) begin
    if (CR) begin
      r_presc <= '0;
      r_idx   <= 3'd5;
      r_snap  <= '0;
      r_an    <= 6'h3F;
      r_seg   <= 7'h7F;
      r_dp    <= 1'b1;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) begin
        r_idx <= w_next_idx;
        if (w_wrap) begin
          r_snap <= w_live;
        end
        if (bus.Disp_EN) begin
          r_an  <= ~(6'b000001 << w_next_idx);
          r_seg <= w_seg;
          r_dp  <= w_dp;
        end else begin
          r_an  <= 6'h3F;
          r_seg <= 7'h7F;
          r_dp  <= 1'b1;
        end
      end
    end
  end

  assign bus.AN  = r_an;
  assign bus.SEG = r_seg;
  assign bus.DP  = r_dp;

endmodule

// File: tb/tb_bcd_scan_display.sv
// tb_bcd_scan_display: directed bench for bcd_scan_display with CLK_DIV = 4.
// Expected {AN,SEG,DP} words are pushed per slot and compared on every cycle
// the slot is held; the summary line reports errors and total checks.
module tb_bcd_scan_display;

  localparam int unsigned Div = 4;
  localparam logic [13:0] RstVec = {6'h3F, 7'h7F, 1'b1};

  logic CP;
  logic CR;

  bcd_scan_display_if bus ();

  bcd_scan_display #(
    .CLK_DIV(Div)
  ) dut (
    .CP  (CP),
    .CR  (CR),
    .bus (bus.slave)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [13:0] exp_q[$];

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  function automatic logic [13:0] expect_of(input int s, input logic [3:0] d,
                                            input logic en, input logic [3:0] secl);
    logic [5:0] an;
    logic       dp;
    if (!en) return RstVec;
    an    = 6'h3F;
    an[s] = 1'b0;
    dp    = 1'b1;
    if (s == 1 || s == 3) begin
`ifdef COLON_BLINK_EN
      dp = secl[0];
`else
      dp = 1'b0;
`endif
    end
    return {an, seg_of(d), dp};
  endfunction

  task automatic step();
    @(posedge CP);
    #1;
  endtask

  // Advance n cycles, comparing the DUT against the head of the scoreboard.
  task automatic check_cycles(input int n, input string tag);
    logic [13:0] obs;
    for (int i = 0; i < n; i++) begin
      step();
      obs = {bus.AN, bus.SEG, bus.DP};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
      end else begin
        assert (obs === exp_q[0]) else begin
          errors++;
          $error("FAIL %s: {AN,SEG,DP} observed %h required %h", tag, obs, exp_q[0]);
        end
      end
    end
  endtask

  task automatic slot(input int s, input logic [3:0] d, input logic en,
                      input logic [3:0] secl, input string tag);
    exp_q.push_back(expect_of(s, d, en, secl));
    check_cycles(Div, tag);
    void'(exp_q.pop_front());
  endtask

  task automatic frame(input logic [3:0] hh, hl, mh, ml, sh, sl, input string tag);
    slot(0, hh, 1'b1, sl, {tag, "_s0"});
    slot(1, hl, 1'b1, sl, {tag, "_s1"});
    slot(2, mh, 1'b1, sl, {tag, "_s2"});
    slot(3, ml, 1'b1, sl, {tag, "_s3"});
    slot(4, sh, 1'b1, sl, {tag, "_s4"});
    slot(5, sl, 1'b1, sl, {tag, "_s5"});
  endtask

  task automatic set_digits(input logic [3:0] hh, hl, mh, ml, sh, sl);
    bus.Hour_H = hh;
    bus.Hour_L = hl;
    bus.Min_H  = mh;
    bus.Min_L  = ml;
    bus.Sec_H  = sh;
    bus.Sec_L  = sl;
  endtask

  initial begin
    CR          = 1'b1;
    bus.Disp_EN = 1'b1;
    set_digits(4'd2, 4'd3, 4'd5, 4'd9, 4'd0, 4'd7);

    // Reset held 3 cycles, then 3 more reset-valued cycles before the first tick.
    exp_q.push_back(RstVec);
    check_cycles(3, "rst_hold");
    CR = 1'b0;
    check_cycles(Div - 1, "rst_release");
    void'(exp_q.pop_front());

    // Frame 1: plain walk.
    frame(4'd2, 4'd3, 4'd5, 4'd9, 4'd0, 4'd7, "f1");

    // Frame 2: Sec_L changes during slot 2; slot 5 keeps the snapshot.
    slot(0, 4'd2, 1'b1, 4'd7, "f2_s0");
    slot(1, 4'd3, 1'b1, 4'd7, "f2_s1");
    exp_q.push_back(expect_of(2, 4'd5, 1'b1, 4'd7));
    check_cycles(2, "f2_s2a");
    bus.Sec_L = 4'd8;
    check_cycles(2, "f2_s2b");
    void'(exp_q.pop_front());
    bus.Min_H = 4'hC;  // also mid-frame; only visible from frame 3
    slot(3, 4'd9, 1'b1, 4'd7, "f2_s3");
    slot(4, 4'd0, 1'b1, 4'd7, "f2_s4");
    slot(5, 4'd7, 1'b1, 4'd7, "f2_s5_snap");

    // Frame 3: new Sec_L and invalid Min_H.
    frame(4'd2, 4'd3, 4'hC, 4'd9, 4'd0, 4'd8, "f3_bad");
    bus.Min_H = 4'd5;

    // Frame 4: display disabled during slot 1, re-enabled during slot 5.
    slot(0, 4'd2, 1'b1, 4'd8, "f4_s0");
    exp_q.push_back(expect_of(1, 4'd3, 1'b1, 4'd8));
    check_cycles(2, "f4_s1a");
    bus.Disp_EN = 1'b0;
    check_cycles(2, "f4_s1b");
    void'(exp_q.pop_front());
    slot(2, 4'd5, 1'b0, 4'd8, "f4_off2");
    slot(3, 4'd9, 1'b0, 4'd8, "f4_off3");
    slot(4, 4'd0, 1'b0, 4'd8, "f4_off4");
    slot(5, 4'd8, 1'b0, 4'd8, "f4_off5");
    bus.Disp_EN = 1'b1;

    // Frame 5: resumes at slot 0; reset asserted during slot 4.
    slot(0, 4'd2, 1'b1, 4'd8, "f5_s0");
    slot(1, 4'd3, 1'b1, 4'd8, "f5_s1");
    slot(2, 4'd5, 1'b1, 4'd8, "f5_s2");
    slot(3, 4'd9, 1'b1, 4'd8, "f5_s3");
    exp_q.push_back(expect_of(4, 4'd0, 1'b1, 4'd8));
    check_cycles(2, "f5_s4");
    void'(exp_q.pop_front());
    CR = 1'b1;
    set_digits(4'd2, 4'd3, 4'd5, 4'd9, 4'd0, 4'd3);
    exp_q.push_back(RstVec);
    check_cycles(1, "midrst");
    CR = 1'b0;
    check_cycles(Div - 1, "midrst_release");
    void'(exp_q.pop_front());

    // Blink frames: odd then even seconds.
    slot(0, 4'd2, 1'b1, 4'd3, "b1_s0");
    bus.Sec_L = 4'd4;
    slot(1, 4'd3, 1'b1, 4'd3, "b1_s1");
    slot(2, 4'd5, 1'b1, 4'd3, "b1_s2");
    slot(3, 4'd9, 1'b1, 4'd3, "b1_s3");
    slot(4, 4'd0, 1'b1, 4'd3, "b1_s4");
    slot(5, 4'd3, 1'b1, 4'd3, "b1_s5");
    frame(4'd2, 4'd3, 4'd5, 4'd9, 4'd0, 4'd4, "b2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net against a stalled run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, observed running required finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bcd_scan_display.md
Name: bcd_scan_display

Overview:
- Reads the six BCD time digits (hour, minute, second; tens and units) produced by the clock counters.
- Drives a 6-digit multiplexed, common-anode 7-segment display: one digit lit per scan slot.
- Sits between the counter chain and the board display pins. It is the consumer (reader) of the counters' BCD outputs.

Parameters:
- CLK_DIV, 50000: CP cycles per scan slot; legal range 2..2^20. The bench uses 4.

Ports:
- CP  input  1  system clock
- CR  input  1  synchronous reset, active-high
- Disp_EN  input  1  1 = display on; 0 = all digits dark, scanning continues
- Hour_H  input  4  hour tens BCD
- Hour_L  input  4  hour units BCD
- Min_H  input  4  minute tens BCD
- Min_L  input  4  minute units BCD
- Sec_H  input  4  second tens BCD
- Sec_L  input  4  second units BCD
- AN  output  6  digit enables, active-low; AN[0] = leftmost digit (Hour_H), AN[5] = Sec_L
- SEG  output  7  segments {g,f,e,d,c,b,a}, active-low
- DP  output  1  decimal point, active-low

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clock port CP, reset port CR).
- All state changes on posedge CP. CR dominates every other input.
- Reset values:
  - prescaler = 0, slot index = 5, snapshot = all zero
  - AN = 6'b111111, SEG = 7'h7F, DP = 1
- Prescaler:
  - counts 0..CLK_DIV-1 and wraps to 0.
  - tick = (prescaler == CLK_DIV-1), one cycle wide.
  - First tick occurs on the CLK_DIV-th cycle after CR is deasserted.
- Slot index advances on each tick: 0,1,2,3,4,5, then 5 wraps to 0.
- Frame snapshot:
  - On a tick where index wraps 5->0, all 24 input bits are registered into the snapshot in that same edge.
  - Digits shown within one frame therefore never tear, even if the counters roll over mid-frame.
  - The inputs are otherwise ignored.
  - The first frame after reset displays the values sampled at the first tick.
- Outputs are registered and update on the tick edge, i.e. the same edge the index changes.
  - AN, SEG and DP reflect the new slot from the cycle after the tick onward.
  - They are held constant for CLK_DIV cycles.
- AN: exactly one bit low (bit = new index) when Disp_EN = 1; all ones when Disp_EN = 0.
  - Disp_EN is sampled at the tick, so it takes effect at the next slot boundary.
- SEG decode (active-low):
  - 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10
  - Codes 10..15 display '-' (0x3F), flagging an invalid BCD value from upstream.
  - Disp_EN = 0 forces SEG = 0x7F.
- DP:
  - Lit (0) on slots 1 and 3, the hour/minute and minute/second separators; 1 on all other slots.
  - Disp_EN = 0 forces DP = 1.
- CR asserted mid-frame: outputs return to reset values on the next edge. The snapshot is cleared; there is no partial-frame carry-over.
- No combinational paths from inputs to outputs.

Optional Feature:
- Macro: COLON_BLINK_EN
- Defined:
  - DP on slots 1 and 3 is lit only when snapshot Sec_L[0] = 0; it is dark on odd seconds.
  - This gives a 0.5 Hz separator blink driven by the seconds count.
  - Slots 0, 2, 4, 5 are unchanged (DP = 1).
- Undefined: DP on slots 1 and 3 is permanently lit while Disp_EN = 1.

Test Plan (CLK_DIV = 4):
- Reset hold: CR=1 for 3 cycles, then release.
  - AN=111111, SEG=7F, DP=1 while CR is high and for 4 cycles after release.
  - The first tick is on the 4th cycle; AN=111110 from the following cycle.
- Full frame: inputs 2,3,5,9,0,7, Disp_EN=1, run 24 cycles.
  - AN walks 111110 -> ... -> 011111, each slot held 4 cycles.
  - SEG sequence: 24,30,12,10,40,78.
  - DP=0 only in slots 1 and 3.
- Snapshot: change Sec_L from 7 to 8 during slot 2.
  - Slot 5 of the current frame still shows 0x78.
  - The next frame's slot 5 shows 0x00.
- Invalid BCD: Min_H = 4'hC.
  - Slot 2 shows SEG=3F; all other slots are unaffected.
- Disp_EN=0 asserted in slot 1.
  - From the next tick: AN=111111, SEG=7F, DP=1.
  - The index keeps advancing; re-enabling resumes at the correct slot.
- Blink (COLON_BLINK_EN defined): Sec_L=3 gives DP=1 on slots 1 and 3; Sec_L=4 in the next frame gives DP=0 on slots 1 and 3.
- Reset mid-frame: CR=1 during slot 4.
  - Reset values on the next edge; restart begins at slot 0 after CLK_DIV cycles.
